fpu_scoreboard: RTL and testbench
=================================

# fpu_scoreboard

Tracks in-flight floating-point register writes and raises a decode-stage stall when an issuing FP instruction would read or overwrite a register whose result is not yet available. Sits directly downstream of the FPU control decoder and consumes its `reg_write`, `use_rs*` and five-level hazard outputs. Keeps one small latency countdown per FP register. Its `stall` output gates the issue stage.

## Interface
Parameters:
- `NREG`, 32: number of FP registers tracked.
- `CNT_W`, 3: countdown width; must satisfy 2^CNT_W > 5.

Ports:
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: an FP/load-FP instruction is presented at decode this cycle.
- `rd` in 5: destination FP register.
- `rs1`, `rs2`, `rs3` in 5 each: source FP registers.
- `use_rs1`, `use_rs2`, `use_rs3` in 1 each: corresponding source is an FP register read. `use_rs3` is driven by the decoder's `is_fmad`.
- `reg_write` in 1: instruction writes an FP register.
- `hazard` in 5: `{is_hazard_4 .. is_hazard_0}` from the decoder.
- `flush` in 1: synchronous clear of all tracking (mispredict/trap).
- `stall` out 1: combinational; hold the issuing instruction this cycle.
- `busy_mask` out NREG: registered; bit i = `cnt[i] != 0`.
- `pending` out 1: registered OR of `busy_mask`.

## Operation
Depth is the priority encoding of `hazard`:
- `hazard[4]` gives 5, `hazard[3]` gives 4, down to `hazard[0]` giving 1, none set gives 0.
- Decoder values: add/sub/cvif = 1, mult/load = 2, fmad = 4, sgn/cmp = 0.

Stall causes; `stall` is the OR of these, each qualified by `issue_valid`:
- RAW: `use_rsK && cnt[rsK] > T`, for any of K = 1, 2, 3. T = 0 without bypass (see Configuration).
- WAW: `reg_write && cnt[rd] != 0 && cnt[rd] >= depth`.

Issue:
- `fire = issue_valid && !stall`.
- On `fire && reg_write && depth != 0`, `cnt[rd]` loads `depth`.

Per-cycle update:
- Every other nonzero counter decrements by 1 each cycle.
- A load on the same register in the same cycle overrides its decrement.
- `reg_write` with depth 0, or an integer-destination op (`reg_write` = 0), leaves the counters untouched.

Flush and reset:
- `flush` forces every `cnt` to 0 next cycle and beats any same-cycle load.
- `stall` is still computed from current counters during the flush cycle.

## Timing
- Reset: all `cnt` = 0, `busy_mask` = 0, `pending` = 0. `stall` = 0 whenever `issue_valid` = 0.
- Reset asserted mid-operation clears all counters immediately (asynchronous). There are no other state elements.
- Issue at cycle N with depth d: `cnt[rd]` = d at N+1 and reaches 0 at N+1+d.
- A dependent reader at N+1 stalls for d cycles without bypass, or d-1 cycles with bypass.
- Counters saturate at 0 and never wrap. Loads never exceed 5.
- `stall` has zero latency (same cycle as inputs). `busy_mask` and `pending` reflect counters one cycle after the update.

## Configuration
- `FPU_SB_BYPASS_EN` defined: RAW threshold T = 1. A source whose counter is 1 does not stall, because the final FPU stage forwards that result.
- Macro undefined: T = 0, so every nonzero counter stalls readers.
- WAW checking is identical in both builds.

## Structure
- Shared package `fpu_pkg`:
  - `NREG`, `CNT_W` and the depth constants (`LAT_ADSB` = 1, `LAT_MULT` = 2, `LAT_LOAD` = 2, `LAT_FMAD` = 4, `LAT_MAX` = 5).
  - The `fpu_cnt_t` typedef.
- One sub-module, `fpu_hazard_depth`: the combinational 5-bit hazard vector to 3-bit depth encoder, reused by any future multi-issue scoreboard.

## Test plan
- Reset with `issue_valid` low -> `busy_mask` = 0, `pending` = 0, `stall` = 0.
- FMUL f3 (hazard = 00011) at cycle 0, then FADD reading f3 presented at cycles 1..3:
  - Without bypass: `stall` = 1 at cycles 1-2, 0 at 3.
  - With `FPU_SB_BYPASS_EN`: `stall` = 1 at cycle 1 only.
- FMADD f5 (hazard = 01111), then FADD f5 (depth 1) next cycle -> WAW stall until `cnt[5]` = 0. Then it issues and `cnt[5]` = 1.
- FLW f7 (depth 2) and a same-cycle decrement of an older f2 counter at 1 -> `cnt[7]` = 2, `cnt[2]` = 0, `busy_mask` = 0x80.
- FMADD f9 (depth 4) issued, `flush` the next cycle -> all counters 0; a reader of f9 at the following cycle sees `stall` = 0.
- `rstn` pulsed low while `cnt[4]` = 3 -> `busy_mask` = 0 asynchronously; FCVT.W.S (integer destination) afterwards never sets any bit.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared constants and types for the FP register scoreboard
//
// Contents:
//   NREG, CNT_W       default register count and countdown width
//   HAZ_W, DEPTH_W    hazard vector width and encoded depth width
//   LAT_*             result latencies as produced by the FPU control decoder
//   fpu_cnt_t         per-register latency countdown
package fpu_pkg;

    localparam int NREG    = 32;
    localparam int CNT_W   = 3;
    localparam int HAZ_W   = 5;
    localparam int DEPTH_W = 3;
    localparam int REG_AW  = 5;

    localparam int LAT_ADSB = 1;
    localparam int LAT_MULT = 2;
    localparam int LAT_LOAD = 2;
    localparam int LAT_FMAD = 4;
    localparam int LAT_MAX  = 5;

    typedef logic [CNT_W-1:0] fpu_cnt_t;

endpackage

// File: rtl/fpu_hazard_depth.sv
// rtl/fpu_hazard_depth.sv - priority encoder from decoder hazard levels to latency depth
//
// Ports:
//   hazard  in  5  {is_hazard_4 .. is_hazard_0}; the highest set bit wins
//   depth   out 3  hazard[k] set (highest) -> k+1; no bit set -> 0
module fpu_hazard_depth
    import fpu_pkg::*;
(
    input  logic [HAZ_W-1:0]   hazard,
    output logic [DEPTH_W-1:0] depth
);

    always_comb begin
        depth = '0;
        casez (hazard)
            5'b1????: depth = 3'd5;
            5'b01???: depth = 3'd4;
            5'b001??: depth = 3'd3;
            5'b0001?: depth = 3'd2;
            5'b00001: depth = 3'd1;
            default:  depth = 3'd0;
        endcase
    end

endmodule

// File: rtl/fpu_scoreboard.sv
// rtl/fpu_scoreboard.sv - FP register write scoreboard raising a decode-stage stall
//
// Optional feature: FPU_SB_BYPASS_EN (defined -> a source whose countdown is 1
// does not stall, since the last FPU stage forwards that result).
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   issue_valid                FP instruction presented at decode
//   rd, rs1, rs2, rs3          destination and source FP registers
//   use_rs1, use_rs2, use_rs3  source is an FP register read
//   reg_write                  instruction writes an FP register
//   hazard                     decoder hazard levels, encoded to a latency depth
//   flush                      clears all tracking on the next edge
//   stall                      combinational: hold the issuing instruction
//   busy_mask                  registered: bit i set while register i is in flight
//   pending                    registered: any register in flight
module fpu_scoreboard
    import fpu_pkg::*;
#(
    parameter int NREG  = fpu_pkg::NREG,
    parameter int CNT_W = fpu_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rs3,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic              use_rs3,
    input  logic              reg_write,
    input  logic [HAZ_W-1:0]  hazard,
    input  logic              flush,
    output logic              stall,
    output logic [NREG-1:0]   busy_mask,
    output logic              pending
);

`ifdef FPU_SB_BYPASS_EN
    localparam logic [CNT_W-1:0] RAW_T = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] RAW_T = '0;
`endif

    logic [CNT_W-1:0]   cnt      [NREG];
    logic [CNT_W-1:0]   cnt_next [NREG];
    logic [NREG-1:0]    busy_next;
    logic [DEPTH_W-1:0] depth;
    logic [CNT_W-1:0]   depth_ext;
    logic               raw_hit;
    logic               waw_hit;
    logic               fire;
    logic               load;

    fpu_hazard_depth u_hazard_depth (
        .hazard (hazard),
        .depth  (depth)
    );

    assign depth_ext = CNT_W'(depth);

    // Hazard checks always look at the current counters, including during a flush.
    always_comb begin
        raw_hit = (use_rs1 && (cnt[rs1] > RAW_T))
               || (use_rs2 && (cnt[rs2] > RAW_T))
               || (use_rs3 && (cnt[rs3] > RAW_T));
        // A newer write may not complete before (or together with) an older one.
        waw_hit = reg_write && (cnt[rd] != '0) && (cnt[rd] >= depth_ext);
        stall   = issue_valid && (raw_hit || waw_hit);
        fire    = issue_valid && !stall;
        load    = fire && reg_write && (depth != '0);
    end

    // Flush beats a load, a load beats the decrement, idle counters rest at zero.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_next[i] = cnt[i];
            if (flush) begin
                cnt_next[i] = '0;
            end else if (load && (rd == REG_AW'(i))) begin
                cnt_next[i] = depth_ext;
            end else if (cnt[i] != '0) begin
                cnt_next[i] = cnt[i] - CNT_W'(1);
            end
            busy_next[i] = (cnt_next[i] != '0);
        end
    end

    // busy_mask/pending are registered from the same next values as the
    // counters, so they always agree with the counter state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            busy_mask <= '0;
            pending   <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= cnt_next[i];
            end
            busy_mask <= busy_next;
            pending   <= |busy_next;
        end
    end

endmodule

// File: tb/tb_fpu_scoreboard.sv
// tb/tb_fpu_scoreboard.sv - self-checking bench for fpu_scoreboard
module tb_fpu_scoreboard;

`ifdef FPU_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int RAW_T = BYP ? 1 : 0;

    logic        clk;
    logic        rstn;
    logic        issue_valid;
    logic [4:0]  rd, rs1, rs2, rs3;
    logic        use_rs1, use_rs2, use_rs3;
    logic        reg_write;
    logic [4:0]  hazard;
    logic        flush;
    logic        stall;
    logic [31:0] busy_mask;
    logic        pending;

    fpu_scoreboard dut (
        .clk         (clk),
        .rstn        (rstn),
        .issue_valid (issue_valid),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs3         (rs3),
        .use_rs1     (use_rs1),
        .use_rs2     (use_rs2),
        .use_rs3     (use_rs3),
        .reg_write   (reg_write),
        .hazard      (hazard),
        .flush       (flush),
        .stall       (stall),
        .busy_mask   (busy_mask),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  rd, rs1, rs2, rs3;
        logic        u1, u2, u3;
        logic        rw;
        logic [4:0]  hz;
        logic        fl;
        logic        exp_stall;
        logic [31:0] exp_busy;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the cycle at which each register's result becomes available.
    int ready_at [32];
    int now = 0;

    function automatic vec_t mk(input logic iv, input logic [4:0] d, input logic [4:0] s1,
                                input logic u1, input logic rw, input logic [4:0] hz,
                                input logic fl, input logic es, input logic [31:0] eb);
        vec_t v;
        v.iv = iv; v.rd = d; v.rs1 = s1; v.rs2 = 5'd0; v.rs3 = 5'd0;
        v.u1 = u1; v.u2 = 1'b0; v.u3 = 1'b0; v.rw = rw; v.hz = hz; v.fl = fl;
        v.exp_stall = es; v.exp_busy = eb;
        return v;
    endfunction

    function automatic int remaining(input logic [4:0] r);
        return (ready_at[r] > now) ? ready_at[r] - now : 0;
    endfunction

    function automatic int depth_of(input logic [4:0] hz);
        for (int b = 4; b >= 0; b--) begin
            if (hz[b]) return b + 1;
        end
        return 0;
    endfunction

    function automatic logic model_stall(input vec_t v);
        logic raw, waw;
        if (!v.iv) return 1'b0;
        raw = (v.u1 && remaining(v.rs1) > RAW_T) || (v.u2 && remaining(v.rs2) > RAW_T)
           || (v.u3 && remaining(v.rs3) > RAW_T);
        waw = v.rw && remaining(v.rd) != 0 && remaining(v.rd) >= depth_of(v.hz);
        return raw || waw;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] m = '0;
        for (int r = 0; r < 32; r++) m[r] = (ready_at[r] > now);
        return m;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        issue_valid = v.iv; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; rs3 = v.rs3;
        use_rs1 = v.u1; use_rs2 = v.u2; use_rs3 = v.u3;
        reg_write = v.rw; hazard = v.hz; flush = v.fl;
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic step(input vec_t v, input bit use_table, input string nm);
        logic        es, ms;
        logic [31:0] eb;
        drive(v);
        #2;
        ms = model_stall(v);
        es = use_table ? v.exp_stall : ms;
        check({nm, " stall"}, {31'd0, stall}, {31'd0, es});
        @(posedge clk);
        if (v.fl) model_clear();
        else if (v.iv && !ms && v.rw && depth_of(v.hz) != 0)
            ready_at[v.rd] = now + 1 + depth_of(v.hz);
        now++;
        #1;
        eb = use_table ? v.exp_busy : model_busy();
        check({nm, " busy_mask"}, busy_mask, eb);
        check({nm, " pending"}, {31'd0, pending}, {31'd0, (eb != 0)});
    endtask

    vec_t idle;
    vec_t tbl[$];

    initial begin
        idle = mk(0, 0, 0, 0, 0, 5'b00000, 0, 0, 32'h0);
        model_clear();

        // FMUL f3 then FADD readers of f3
        tbl.push_back(mk(1,  3, 0, 0, 1, 5'b00011, 0, 0, 32'h8));
        tbl.push_back(mk(1, 10, 3, 1, 1, 5'b00001, 0, 1, 32'h8));
        tbl.push_back(mk(1, 10, 3, 1, 1, 5'b00001, 0, !BYP, BYP ? 32'h400 : 32'h0));
        tbl.push_back(mk(1, 11, 3, 1, 1, 5'b00001, 0, 0, 32'h800));
        tbl.push_back(mk(0,  0, 0, 0, 0, 5'b00000, 0, 0, 32'h0));
        // FMADD f5 then FADD f5: WAW until the counter drains
        tbl.push_back(mk(1,  5, 0, 0, 1, 5'b01111, 0, 0, 32'h20));
        tbl.push_back(mk(1,  5, 0, 0, 1, 5'b00001, 0, 1, 32'h20));
        tbl.push_back(mk(1,  5, 0, 0, 1, 5'b00001, 0, 1, 32'h20));
        tbl.push_back(mk(1,  5, 0, 0, 1, 5'b00001, 0, 1, 32'h20));
        tbl.push_back(mk(1,  5, 0, 0, 1, 5'b00001, 0, 1, 32'h0));
        tbl.push_back(mk(1,  5, 0, 0, 1, 5'b00001, 0, 0, 32'h20));
        tbl.push_back(mk(0,  0, 0, 0, 0, 5'b00000, 0, 0, 32'h0));
        // FLW f7 while f2 decrements from 1
        tbl.push_back(mk(1,  2, 0, 0, 1, 5'b00001, 0, 0, 32'h4));
        tbl.push_back(mk(1,  7, 0, 0, 1, 5'b00011, 0, 0, 32'h80));
        tbl.push_back(mk(0,  0, 0, 0, 0, 5'b00000, 0, 0, 32'h80));
        tbl.push_back(mk(0,  0, 0, 0, 0, 5'b00000, 0, 0, 32'h0));
        // FMADD f9 then flush; flush also beats a same-cycle load
        tbl.push_back(mk(1,  9, 0, 0, 1, 5'b01111, 0, 0, 32'h200));
        tbl.push_back(mk(1, 12, 9, 1, 1, 5'b00001, 1, 1, 32'h0));
        tbl.push_back(mk(1,  0, 9, 1, 0, 5'b00000, 0, 0, 32'h0));
        tbl.push_back(mk(1, 12, 0, 0, 1, 5'b00001, 1, 0, 32'h0));
        tbl.push_back(mk(1, 13, 0, 0, 1, 5'b10000, 0, 0, 32'h2000));

        drive(idle);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        now++;
        #1;
        check("reset busy_mask", busy_mask, 32'h0);
        check("reset pending", {31'd0, pending}, 32'h0);
        check("reset stall", {31'd0, stall}, 32'h0);

        foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("vec%0d", i));
        repeat (6) step(idle, 1'b0, "drain");

        // Asynchronous reset while cnt[4] = 3, then an integer-destination op
        step(mk(1, 4, 0, 0, 1, 5'b00111, 0, 0, 32'h10), 1'b1, "load f4");
        drive(idle);
        #2;
        rstn = 1'b0;
        #1;
        check("async busy_mask", busy_mask, 32'h0);
        check("async pending", {31'd0, pending}, 32'h0);
        model_clear();
        #1;
        rstn = 1'b1;
        @(posedge clk);
        now++;
        #1;
        step(mk(1, 6, 4, 1, 0, 5'b00001, 0, 0, 32'h0), 1'b1, "fcvt.w.s a");
        step(mk(1, 6, 4, 1, 0, 5'b00001, 0, 0, 32'h0), 1'b1, "fcvt.w.s b");
        step(idle, 1'b1, "post fcvt");

        // Randomised traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            vec_t v;
            v.iv  = ($urandom_range(0, 3) != 0);
            v.rd  = 5'($urandom_range(0, 7));
            v.rs1 = 5'($urandom_range(0, 7));
            v.rs2 = 5'($urandom_range(0, 7));
            v.rs3 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            v.u1  = 1'($urandom_range(0, 1));
            v.u2  = 1'($urandom_range(0, 1));
            v.u3  = ($urandom_range(0, 3) == 0);
            v.rw  = ($urandom_range(0, 4) != 0);
            v.hz  = 5'($urandom_range(0, 31));
            v.fl  = ($urandom_range(0, 15) == 0);
            v.exp_stall = 1'b0;
            v.exp_busy  = '0;
            step(v, 1'b0, $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
